// File: rtl/brent_kung_pipe_adder.sv
// brent_kung_pipe_adder
//   Pipelined Brent-Kung adder/subtractor with valid/ready handshaking on both
//   sides. The prefix tree is padded to the next power of two above `bits`.
//   PIPE register stages are spread evenly across the prefix levels, and the
//   last stage always drives the outputs directly from registers. Latency is
//   exactly PIPE cycles and the whole pipeline stalls together.
//
// Parameters
//   bits  operand width (>= 2)
//   PIPE  register stages / latency, 1 .. 2*clog2(bits)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = out_ready | ~out_valid)
//   A, B, Cin, sub       operands; sub=1 computes A - B and ignores Cin
//   out_valid/out_ready  output handshake
//   SUM, Cout            result and carry-out (not-borrow when subtracting)
//   ovf, zero, neg       signed overflow, SUM==0, SUM MSB
//
// Build option
//   BK_ADDER_FLAGS_EN    when defined, ovf/zero/neg are computed and registered;
//                        otherwise those ports are tied to 0.
module brent_kung_pipe_adder #(
    parameter int bits = 64,
    parameter int PIPE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    input  logic            Cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits-1:0] SUM,
    output logic            Cout,
    output logic            ovf,
    output logic            zero,
    output logic            neg
);

    localparam int LOG = $clog2(bits);
    localparam int N   = 1 << LOG;
    // Level 0 forms g/p, levels 1..LOG are the up-sweep, the rest the down-sweep.
    localparam int L   = 2 * LOG - 1;
    localparam int NL  = L + 1;

    // True when a pipeline register follows prefix level l. PIPE-1 registers
    // are spread over the NL level boundaries; the final register after the
    // sum logic is always present. Position 0 comes first, so when PIPE >= 2
    // the formed operands and g/p are captured right away.
    function automatic bit is_reg(input int l);
        bit r;
        r = 1'b0;
        for (int k = 0; k < PIPE - 1; k++) begin
            if ((k * NL) / (PIPE - 1) == l) r = 1'b1;
        end
        return r;
    endfunction

    // Distance to the partner bit that bit i combines with at level l (0 = none).
    function automatic int span(input int l, input int i);
        int d;
        int r;
        r = 0;
        d = 0;
        if (l >= 1 && l <= LOG) begin
            if (((i + 1) % (1 << l)) == 0) r = 1 << (l - 1);
        end else if (l > LOG) begin
            d = 2 * LOG - l;
            if (d >= 1 && i >= (1 << d) && ((i + 1) % (1 << d)) == (1 << (d - 1)))
                r = 1 << (d - 1);
        end
        return r;
    endfunction

    logic            adv;
    logic [PIPE-1:0] v_reg;

    assign out_valid = v_reg[PIPE-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    genvar gl, gi;
    generate
        for (gl = 0; gl <= L; gl++) begin : lvl
            logic [N-1:0]    g_c, p_c, g_q, p_q;
            logic [bits-1:0] x_c, x_q;   // per-bit propagate, kept for the final XOR
            logic            ci_c, ci_q; // effective carry-in

            if (gl == 0) begin : form
                logic [bits-1:0] b_eff;
                assign b_eff = sub ? ~B : B;
                assign ci_c  = sub | Cin;
                assign x_c   = A ^ b_eff;
                for (gi = 0; gi < N; gi++) begin : bitg
                    if (gi == 0) begin : b0
                        // Folding the carry-in into bit 0 makes every group
                        // generate ending at bit 0 the true carry out of bit i.
                        assign g_c[gi] = (A[0] & b_eff[0]) | (x_c[0] & ci_c);
                        assign p_c[gi] = x_c[0];
                    end else if (gi < bits) begin : bn
                        assign g_c[gi] = A[gi] & b_eff[gi];
                        assign p_c[gi] = x_c[gi];
                    end else begin : pad
                        assign g_c[gi] = 1'b0;
                        assign p_c[gi] = 1'b0;
                    end
                end
            end else begin : pfx
                assign x_c  = lvl[gl-1].x_q;
                assign ci_c = lvl[gl-1].ci_q;
                for (gi = 0; gi < N; gi++) begin : bitp
                    localparam int D = span(gl, gi);
                    if (D > 0) begin : op
                        assign g_c[gi] = lvl[gl-1].g_q[gi] | (lvl[gl-1].p_q[gi] & lvl[gl-1].g_q[gi-D]);
                        // Group propagate is only needed while building the up-sweep.
                        if (gl <= LOG) begin : up
                            assign p_c[gi] = lvl[gl-1].p_q[gi] & lvl[gl-1].p_q[gi-D];
                        end else begin : dn
                            assign p_c[gi] = lvl[gl-1].p_q[gi];
                        end
                    end else begin : thru
                        assign g_c[gi] = lvl[gl-1].g_q[gi];
                        assign p_c[gi] = lvl[gl-1].p_q[gi];
                    end
                end
            end

            if (is_reg(gl)) begin : r
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        g_q  <= '0;
                        p_q  <= '0;
                        x_q  <= '0;
                        ci_q <= 1'b0;
                    end else if (adv) begin
                        g_q  <= g_c;
                        p_q  <= p_c;
                        x_q  <= x_c;
                        ci_q <= ci_c;
                    end
                end
            end else begin : w
                assign g_q  = g_c;
                assign p_q  = p_c;
                assign x_q  = x_c;
                assign ci_q = ci_c;
            end
        end

        if (PIPE == 1) begin : v1
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      v_reg <= '0;
                else if (adv) v_reg <= in_valid;
            end
        end else begin : vn
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      v_reg <= '0;
                else if (adv) v_reg <= {v_reg[PIPE-2:0], in_valid};
            end
        end
    endgenerate

    // Final sum: carry into bit i is the group generate of bits i-1..0.
    logic [N-1:0]    g_f;
    logic [bits-1:0] carry_vec, sum_c;
    logic            cout_c;

    assign g_f       = lvl[L].g_q;
    assign carry_vec = {g_f[bits-2:0], lvl[L].ci_q};
    assign sum_c     = lvl[L].x_q ^ carry_vec;
    assign cout_c    = g_f[bits-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SUM  <= '0;
            Cout <= 1'b0;
        end else if (adv) begin
            SUM  <= sum_c;
            Cout <= cout_c;
        end
    end

`ifdef BK_ADDER_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (adv) begin
            ovf  <= carry_vec[bits-1] ^ cout_c;
            zero <= ~|sum_c;
            neg  <= sum_c[bits-1];
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif

endmodule
